// File: rtl/commit_trace_buffer_if.sv
// Commit trace buffer bus: per-channel retire inputs, the record
// drain handshake and the status/counter outputs.
interface commit_trace_buffer_if #(
   parameter int NUM_CH = 2,
   parameter int DEPTH  = 16,
   parameter int DATA_W = 16,
   parameter int REG_W  = 3,
   parameter int CNT_W  = 32
);
   localparam int REC_W = 4 + REG_W + 4 * DATA_W;
   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic                       enable;
   logic [NUM_CH-1:0]          cm_valid;
   logic [NUM_CH*DATA_W-1:0]   cm_pc;
   logic [NUM_CH-1:0]          cm_reg_write;
   logic [NUM_CH*REG_W-1:0]    cm_write_reg;
   logic [NUM_CH*DATA_W-1:0]   cm_write_data;
   logic [NUM_CH-1:0]          cm_mem_read;
   logic [NUM_CH-1:0]          cm_mem_write;
   logic [NUM_CH*DATA_W-1:0]   cm_mem_addr;
   logic [NUM_CH*DATA_W-1:0]   cm_mem_data;
   logic [NUM_CH-1:0]          cm_halt;
   logic                       rec_valid;
   logic                       rec_ready;
   logic [REC_W-1:0]           rec_data;
   logic [OCC_W-1:0]           occupancy;
   logic                       halted;
   logic [CNT_W-1:0]           cycle_count;
   logic [CNT_W-1:0]           inst_count;
   logic [CNT_W-1:0]           drop_count;

   modport master (
      output enable, cm_valid, cm_pc, cm_reg_write,
      output cm_write_reg, cm_write_data, cm_mem_read,
      output cm_mem_write, cm_mem_addr, cm_mem_data,
      output cm_halt, rec_ready,
      input  rec_valid, rec_data, occupancy, halted,
      input  cycle_count, inst_count, drop_count
   );

   modport slave (
      input  enable, cm_valid, cm_pc, cm_reg_write,
      input  cm_write_reg, cm_write_data, cm_mem_read,
      input  cm_mem_write, cm_mem_addr, cm_mem_data,
      input  cm_halt, rec_ready,
      output rec_valid, rec_data, occupancy, halted,
      output cycle_count, inst_count, drop_count
   );
endinterface

// File: rtl/commit_trace_buffer.sv
// Multi-retire commit trace buffer: packs live commits into records,
// queues them in a FIFO and freezes capture on the first halt.
module commit_trace_buffer #(
   parameter int NUM_CH = 2,
   parameter int DEPTH  = 16,
   parameter int DATA_W = 16,
   parameter int REG_W  = 3,
   parameter int CNT_W  = 32
) (
   input logic                 clk,
   input logic                 rst,
   commit_trace_buffer_if.slave bus
);
   localparam int REC_W = 4 + REG_W + 4 * DATA_W;
   localparam int AW    = $clog2(DEPTH);
   localparam int OW    = AW + 1;
   localparam int CW    = (OW > 3) ? OW : 3;

   logic [REC_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [OW-1:0]    r_occ;
   logic             r_halted;
   logic [REC_W-1:0] r_rec;
   logic [CNT_W-1:0] r_cyc;
   logic [CNT_W-1:0] r_inst;
   logic [CNT_W-1:0] r_drop;

   logic [REC_W-1:0] w_rec [NUM_CH];
   logic [CW-1:0]    w_rank [NUM_CH];
   logic [AW-1:0]    w_waddr [NUM_CH];
   logic [NUM_CH-1:0] w_live;
   logic [NUM_CH-1:0] w_wen;
   logic             w_run;
   logic             w_blk;
   logic             w_hlive;
   logic             w_hov;
   logic             w_pop;
   logic [REC_W-1:0] w_hrec;
   logic [REC_W-1:0] w_head_nxt;
   logic [CW-1:0]    w_nlive;
   logic [CW-1:0]    w_free;
   logic [CW-1:0]    w_npush;
   logic [CW-1:0]    w_ndrop;
   logic [AW-1:0]    w_hov_addr;
   logic [AW-1:0]    w_rd_nxt;
   logic [OW-1:0]    w_occ_nxt;

   function automatic logic [CNT_W-1:0] f_sat(
      input logic [CNT_W-1:0] a,
      input logic [CW-1:0]    b
   );
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(b);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   for (genvar g = 0; g < NUM_CH; g++) begin : g_rec
      assign w_rec[g] = {
         bus.cm_halt[g],
         bus.cm_mem_write[g],
         bus.cm_mem_read[g],
         bus.cm_reg_write[g],
         bus.cm_write_reg[g*REG_W +: REG_W],
         bus.cm_pc[g*DATA_W +: DATA_W],
         bus.cm_write_data[g*DATA_W +: DATA_W],
         bus.cm_mem_addr[g*DATA_W +: DATA_W],
         bus.cm_mem_data[g*DATA_W +: DATA_W]
      };
   end

   // Live channels end at the first valid halt, which is the halt record.
   always_comb begin
      w_live  = '0;
      w_hlive = 1'b0;
      w_hrec  = '0;
      w_nlive = '0;
      w_blk   = 1'b0;
      w_run   = bus.enable & ~r_halted;
      for (int i = 0; i < NUM_CH; i++) begin
         w_rank[i] = w_nlive;
         if (w_run && !w_blk && bus.cm_valid[i]) begin
            w_live[i] = 1'b1;
            w_nlive   = w_nlive + CW'(1);
            if (bus.cm_halt[i]) begin
               w_hlive = 1'b1;
               w_hrec  = w_rec[i];
               w_blk   = 1'b1;
            end
         end
      end
   end

   // Slot allocation, halt overwrite and next-head bypass.
   always_comb begin
      w_free     = CW'(DEPTH) - CW'(r_occ);
      w_npush    = (w_nlive < w_free) ? w_nlive : w_free;
      w_ndrop    = w_nlive - w_npush;
      w_hov      = w_hlive & (w_nlive > w_free);
      w_hov_addr = r_wr + AW'(w_npush) - AW'(1);
      w_pop      = (r_occ != '0) & bus.rec_ready;
      w_rd_nxt   = r_rd + AW'(w_pop);
      w_occ_nxt  = r_occ + OW'(w_npush) - OW'(w_pop);
      w_head_nxt = r_mem[w_rd_nxt];
      for (int i = 0; i < NUM_CH; i++) begin
         w_wen[i]   = w_live[i] && (w_rank[i] < w_npush);
         w_waddr[i] = r_wr + AW'(w_rank[i]);
         if (w_wen[i] && (w_waddr[i] == w_rd_nxt))
            w_head_nxt = w_rec[i];
      end
      if (w_hov && (w_hov_addr == w_rd_nxt))
         w_head_nxt = w_hrec;
   end

   // Record storage; the halt overwrite is issued last so it wins.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++)
         if (w_wen[i])
            r_mem[w_waddr[i]] <= w_rec[i];
      if (w_hov)
         r_mem[w_hov_addr] <= w_hrec;
   end

   // Pointers, occupancy, registered head and sticky halt.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr     <= '0;
         r_rd     <= '0;
         r_occ    <= '0;
         r_rec    <= '0;
         r_halted <= 1'b0;
      end else begin
         r_wr  <= r_wr + AW'(w_npush);
         r_rd  <= w_rd_nxt;
         r_occ <= w_occ_nxt;
         if (w_occ_nxt != '0)
            r_rec <= w_head_nxt;
         if (w_hlive)
            r_halted <= 1'b1;
      end
   end

   // Saturating cycle, instruction and drop counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cyc  <= '0;
         r_inst <= '0;
         r_drop <= '0;
      end else if (w_run) begin
         r_cyc  <= f_sat(r_cyc, CW'(1));
         r_inst <= f_sat(r_inst, w_nlive);
         r_drop <= f_sat(r_drop, w_ndrop);
      end
   end

   assign bus.rec_valid   = (r_occ != '0);
   assign bus.rec_data    = r_rec;
   assign bus.occupancy   = r_occ;
   assign bus.halted      = r_halted;
   assign bus.cycle_count = r_cyc;
   assign bus.inst_count  = r_inst;
   assign bus.drop_count  = r_drop;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: directed cases
// followed by randomized segments against a queue model.
module tb_commit_trace_buffer;
   localparam int NC   = 2;
   localparam int DP   = 4;
   localparam int DW   = 16;
   localparam int RW   = 3;
   localparam int CNW  = 32;
   localparam int RECW = 4 + RW + 4 * DW;
   localparam int PCL  = 3 * DW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   commit_trace_buffer_if #(
      .NUM_CH(NC), .DEPTH(DP), .DATA_W(DW),
      .REG_W(RW), .CNT_W(CNW)
   ) bus ();

   commit_trace_buffer #(
      .NUM_CH(NC), .DEPTH(DP), .DATA_W(DW),
      .REG_W(RW), .CNT_W(CNW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;
   logic [RECW-1:0] mq [$];
   longint m_cyc, m_inst, m_drop;
   bit m_halt;
   longint snap;

   task automatic chk(string nm, logic [127:0] act,
                      logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic longint sat(longint x);
      return (x > 64'h0000_0000_FFFF_FFFF) ?
             64'h0000_0000_FFFF_FFFF : x;
   endfunction

   function automatic logic [RECW-1:0] pack(int i);
      return {bus.cm_halt[i], bus.cm_mem_write[i],
              bus.cm_mem_read[i], bus.cm_reg_write[i],
              bus.cm_write_reg[i*RW +: RW],
              bus.cm_pc[i*DW +: DW],
              bus.cm_write_data[i*DW +: DW],
              bus.cm_mem_addr[i*DW +: DW],
              bus.cm_mem_data[i*DW +: DW]};
   endfunction

   // Reference: commits in program order until a halt; the FIFO
   // takes what fits, a halt that does not fit replaces the newest.
   task automatic model_cycle();
      int nl, nd, free;
      bit hl;
      logic [RECW-1:0] r;
      nl = 0; nd = 0; hl = 0;
      if (!bus.enable || m_halt) return;
      m_cyc = sat(m_cyc + 1);
      free = DP - mq.size();
      for (int i = 0; i < NC && !hl; i++) begin
         if (bus.cm_valid[i]) begin
            r = pack(i);
            if (nl < free) mq.push_back(r);
            else begin
               nd++;
               if (bus.cm_halt[i]) mq[mq.size()-1] = r;
            end
            nl++;
            if (bus.cm_halt[i]) hl = 1;
         end
      end
      m_inst = sat(m_inst + nl);
      m_drop = sat(m_drop + nd);
      if (hl) m_halt = 1;
   endtask

   task automatic check_state(string t);
      chk({t, ".occ"}, bus.occupancy, mq.size());
      chk({t, ".valid"}, bus.rec_valid, mq.size() != 0);
      chk({t, ".halted"}, bus.halted, m_halt);
      chk({t, ".cyc"}, bus.cycle_count, m_cyc);
      chk({t, ".inst"}, bus.inst_count, m_inst);
      chk({t, ".drop"}, bus.drop_count, m_drop);
   endtask

   task automatic step(string t);
      model_cycle();
      @(posedge clk);
      #1;
      check_state(t);
   endtask

   task automatic clr();
      bus.cm_valid      = '0;
      bus.cm_pc         = '0;
      bus.cm_reg_write  = '0;
      bus.cm_write_reg  = '0;
      bus.cm_write_data = '0;
      bus.cm_mem_read   = '0;
      bus.cm_mem_write  = '0;
      bus.cm_mem_addr   = '0;
      bus.cm_mem_data   = '0;
      bus.cm_halt       = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      mq.delete();
      m_cyc = 0; m_inst = 0; m_drop = 0; m_halt = 0;
      #1;
      chk("rst.valid", bus.rec_valid, 0);
      chk("rst.occ", bus.occupancy, 0);
      chk("rst.data", bus.rec_data, 0);
      chk("rst.halted", bus.halted, 0);
      chk("rst.cyc", bus.cycle_count, 0);
      chk("rst.inst", bus.inst_count, 0);
      chk("rst.drop", bus.drop_count, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic rand_in(int rdy_pct, int hdiv);
      bus.enable    = ($urandom_range(0, 9) != 0);
      bus.rec_ready = ($urandom_range(0, 99) < rdy_pct);
      for (int i = 0; i < NC; i++) begin
         bus.cm_valid[i]     = $urandom_range(0, 1) != 0;
         bus.cm_halt[i]      = (hdiv != 0) &&
                               ($urandom_range(0, hdiv) == 0);
         bus.cm_reg_write[i] = $urandom_range(0, 1) != 0;
         bus.cm_mem_read[i]  = $urandom_range(0, 1) != 0;
         bus.cm_mem_write[i] = $urandom_range(0, 1) != 0;
         bus.cm_write_reg[i*RW +: RW]  = RW'($urandom);
         bus.cm_pc[i*DW +: DW]         = DW'($urandom);
         bus.cm_write_data[i*DW +: DW] = DW'($urandom);
         bus.cm_mem_addr[i*DW +: DW]   = DW'($urandom);
         bus.cm_mem_data[i*DW +: DW]   = DW'($urandom);
      end
   endtask

   // Monitor: head record must match the model queue front.
   initial forever begin
      @(negedge clk);
      if (rst && bus.rec_valid) begin
         chk("mon.q_nonempty", mq.size() != 0, 1);
         if (mq.size() != 0) begin
            chk("mon.rec", bus.rec_data, mq[0]);
            if (bus.rec_ready) void'(mq.pop_front());
         end
      end
   end

   initial begin
      clr();
      bus.enable    = 1'b1;
      bus.rec_ready = 1'b0;
      #2;
      do_reset();

      for (int k = 0; k < 3; k++) begin
         clr();
         bus.cm_valid = 2'b01;
         bus.cm_pc[0 +: DW] = DW'(2 * k);
         step("fill");
      end
      chk("fill.occ3", bus.occupancy, 3);
      chk("fill.inst3", bus.inst_count, 3);
      chk("fill.cyc3", bus.cycle_count, 3);
      chk("fill.pc0", bus.rec_data[PCL +: DW], 0);

      clr();
      bus.cm_valid = 2'b11;
      bus.cm_pc = {DW'(16'h0008), DW'(16'h0006)};
      bus.rec_ready = 1'b1;
      step("full");
      chk("full.occ", bus.occupancy, 3);
      chk("full.drop", bus.drop_count, 1);
      chk("full.inst", bus.inst_count, 5);

      clr();
      for (int k = 0; k < 3; k++) step("drain");

      bus.rec_ready = 1'b0;
      bus.cm_valid = 2'b01;
      bus.cm_mem_write = 2'b01;
      bus.cm_pc[0 +: DW] = DW'(16'h0010);
      bus.cm_mem_addr[0 +: DW] = DW'(16'h0040);
      bus.cm_mem_data[0 +: DW] = DW'(16'hBEEF);
      step("store");
      chk("store.flags", bus.rec_data[RECW-1 -: 4], 4'b0100);
      chk("store.addr", bus.rec_data[DW +: DW], 16'h0040);
      chk("store.data", bus.rec_data[0 +: DW], 16'hBEEF);

      for (int k = 0; k < 3; k++) begin
         clr();
         bus.cm_valid = 2'b01;
         bus.cm_pc[0 +: DW] = DW'(16'h0100 + k);
         step("fill4");
      end
      clr();
      bus.cm_valid = 2'b01;
      bus.cm_halt = 2'b01;
      bus.cm_pc[0 +: DW] = DW'(16'h0099);
      step("hfull");
      chk("hfull.occ", bus.occupancy, 4);
      chk("hfull.drop", bus.drop_count, 2);
      chk("hfull.halted", bus.halted, 1);
      snap = longint'(bus.cycle_count);
      clr();
      bus.cm_valid = 2'b11;
      bus.rec_ready = 1'b1;
      for (int k = 0; k < 5; k++) step("hdrain");
      chk("hdrain.cyc", bus.cycle_count, snap);
      chk("hdrain.occ", bus.occupancy, 0);

      bus.rec_ready = 1'b0;
      do_reset();
      clr();
      bus.cm_valid = 2'b11;
      bus.cm_halt = 2'b01;
      bus.cm_pc = {DW'(16'h0022), DW'(16'h0020)};
      step("sh");
      chk("sh.occ", bus.occupancy, 1);
      chk("sh.inst", bus.inst_count, 1);
      chk("sh.halted", bus.halted, 1);
      chk("sh.hbit", bus.rec_data[RECW-1], 1);
      chk("sh.pc", bus.rec_data[PCL +: DW], 16'h0020);
      clr();
      bus.cm_valid = 2'b11;
      step("sh2");
      step("sh2");
      chk("sh2.inst", bus.inst_count, 1);
      chk("sh2.cyc", bus.cycle_count, 1);

      do_reset();
      for (int k = 0; k < 2; k++) begin
         clr();
         bus.cm_valid = 2'b01;
         bus.cm_pc[0 +: DW] = DW'(16'h0050 + k);
         step("pre");
      end
      chk("pre.occ", bus.occupancy, 2);
      do_reset();
      clr();
      bus.cm_valid = 2'b01;
      bus.cm_pc[0 +: DW] = DW'(16'h0077);
      step("resume");
      chk("resume.occ", bus.occupancy, 1);
      chk("resume.inst", bus.inst_count, 1);
      chk("resume.pc", bus.rec_data[PCL +: DW], 16'h0077);

      for (int s = 0; s < 8; s++) begin
         do_reset();
         for (int c = 0; c < 200; c++) begin
            rand_in((s % 3) * 40 + 10, (s % 2) ? 0 : 80);
            step("rnd");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
